// File: rtl/time_set_ctrl.sv
// time_set_ctrl: edit-mode controller for setting calendar time from the five
// debounced front-panel buttons. Middle enters edit (snapshotting cur_*),
// left/right pick a field, up/down step it with wrap and auto-repeat, and a
// second middle press strobes load for one cycle before returning to idle.
module time_set_ctrl #(
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 5_000_000,
  parameter int unsigned YEAR_MIN   = 2000,
  parameter int unsigned YEAR_MAX   = 2099
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_mid,
  input  logic [15:0] cur_year,
  input  logic [3:0]  cur_month,
  input  logic [4:0]  cur_day,
  input  logic [4:0]  cur_hour,
  input  logic [5:0]  cur_minute,
  input  logic [5:0]  cur_second,
  output logic        set_active,
  output logic [2:0]  field_sel,
  output logic [15:0] edit_year,
  output logic [3:0]  edit_month,
  output logic [4:0]  edit_day,
  output logic [4:0]  edit_hour,
  output logic [5:0]  edit_minute,
  output logic [5:0]  edit_second,
  output logic        load
);

  typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_COMMIT} state_t;

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  // The press edge already clears the counter and counts as the first held
  // cycle, so the first repeat fires when the counter reaches REPEAT_DLY-2.
  localparam logic [CW-1:0] DLY_LIM = CW'(REPEAT_DLY - 2);
  localparam logic [CW-1:0] PER_LIM = CW'(REPEAT_PER - 1);
  localparam logic [15:0]   Y_MIN   = 16'(YEAR_MIN);
  localparam logic [15:0]   Y_MAX   = 16'(YEAR_MAX);

  state_t          state, state_nxt;
  logic [4:0]      btn_prev;
  logic            press_up, press_down, press_left, press_right, press_mid;
  logic [CW-1:0]   rep_cnt, rep_cnt_nxt, rep_lim;
  logic            rep_run, rep_run_nxt, rep_fire;
  logic            fld_move, ud_one;
  logic [2:0]      field_nxt;
  logic [15:0]     year_nxt;
  logic [3:0]      month_nxt;
  logic [4:0]      day_nxt, hour_nxt, dim_cur, dim_new;
  logic [5:0]      minute_nxt, second_nxt;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [15:0] y);
    logic leap;
    leap = (((y % 16'd4) == 16'd0) && ((y % 16'd100) != 16'd0)) || ((y % 16'd400) == 16'd0);
    case (m)
      4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  // Out-of-range snapshots fall onto the wrap edge instead of running away.
  function automatic logic [15:0] wrap_step(input logic [15:0] v, input logic [15:0] lo,
                                            input logic [15:0] hi, input logic up);
    if (up) wrap_step = (v >= hi) ? lo : v + 16'd1;
    else    wrap_step = (v <= lo) ? hi : v - 16'd1;
  endfunction

  assign press_up    = btn_up    & ~btn_prev[0];
  assign press_down  = btn_down  & ~btn_prev[1];
  assign press_left  = btn_left  & ~btn_prev[2];
  assign press_right = btn_right & ~btn_prev[3];
  assign press_mid   = btn_mid   & ~btn_prev[4];

  // Button history for rising-edge detection, tracked in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) btn_prev <= '0;
    else        btn_prev <= {btn_mid, btn_right, btn_left, btn_down, btn_up};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: middle press toggles idle/edit, commit lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (press_mid) state_nxt = ST_EDIT;
      ST_EDIT:   if (press_mid) state_nxt = ST_COMMIT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    set_active = (state == ST_EDIT);
    load       = (state == ST_COMMIT);
  end

  // Edit datapath: snapshot, field select, stepping with clamp, auto-repeat.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    field_nxt   = field_sel;
    year_nxt    = edit_year;
    month_nxt   = edit_month;
    day_nxt     = edit_day;
    hour_nxt    = edit_hour;
    minute_nxt  = edit_minute;
    second_nxt  = edit_second;
    rep_cnt_nxt = '0;
    rep_run_nxt = 1'b0;
    rep_fire    = 1'b0;
    fld_move    = press_left ^ press_right;
    ud_one      = btn_up ^ btn_down;
    rep_lim     = rep_run ? PER_LIM : DLY_LIM;
    dim_cur     = days_in_month(edit_month, edit_year);
    dim_new     = dim_cur;

    case (state)
      ST_IDLE: begin
        if (press_mid) begin
          year_nxt   = cur_year;
          month_nxt  = cur_month;
          day_nxt    = cur_day;
          hour_nxt   = cur_hour;
          minute_nxt = cur_minute;
          second_nxt = cur_second;
          field_nxt  = 3'd0;
        end
      end
      ST_EDIT: begin
        if (ud_one && !press_up && !press_down && !fld_move && !press_mid) begin
          if (rep_cnt == rep_lim) begin
            rep_fire    = 1'b1;
            rep_run_nxt = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
            rep_run_nxt = rep_run;
          end
        end

        if (press_mid) begin
          // leaving edit; values hold through commit
        end else if (fld_move) begin
          if (press_left) field_nxt = (field_sel >= 3'd5) ? 3'd0 : field_sel + 3'd1;
          else            field_nxt = (field_sel == 3'd0) ? 3'd5 : field_sel - 3'd1;
        end else if (ud_one && (press_up || press_down || rep_fire)) begin
          case (field_sel)
            3'd0: second_nxt = 6'(wrap_step({10'd0, edit_second}, 16'd0, 16'd59, btn_up));
            3'd1: minute_nxt = 6'(wrap_step({10'd0, edit_minute}, 16'd0, 16'd59, btn_up));
            3'd2: hour_nxt   = 5'(wrap_step({11'd0, edit_hour}, 16'd0, 16'd23, btn_up));
            3'd3: day_nxt    = 5'(wrap_step({11'd0, edit_day}, 16'd1, {11'd0, dim_cur}, btn_up));
            3'd4: begin
              month_nxt = 4'(wrap_step({12'd0, edit_month}, 16'd1, 16'd12, btn_up));
              dim_new   = days_in_month(month_nxt, edit_year);
              if (edit_day > dim_new) day_nxt = dim_new;
            end
            default: begin
              year_nxt = wrap_step(edit_year, Y_MIN, Y_MAX, btn_up);
              dim_new  = days_in_month(edit_month, year_nxt);
              if (edit_day > dim_new) day_nxt = dim_new;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Edit registers and auto-repeat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_sel   <= 3'd0;
      edit_year   <= Y_MIN;
      edit_month  <= 4'd1;
      edit_day    <= 5'd1;
      edit_hour   <= 5'd0;
      edit_minute <= 6'd0;
      edit_second <= 6'd0;
      rep_cnt     <= '0;
      rep_run     <= 1'b0;
    end else begin
      field_sel   <= field_nxt;
      edit_year   <= year_nxt;
      edit_month  <= month_nxt;
      edit_day    <= day_nxt;
      edit_hour   <= hour_nxt;
      edit_minute <= minute_nxt;
      edit_second <= second_nxt;
      rep_cnt     <= rep_cnt_nxt;
      rep_run     <= rep_run_nxt;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed testbench for time_set_ctrl with short auto-repeat timing.
module tb_time_set_ctrl;

  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_MID   = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btns = '0;
  logic [15:0] cur_year = 16'd0;
  logic [3:0]  cur_month = 4'd0;
  logic [4:0]  cur_day = 5'd0, cur_hour = 5'd0;
  logic [5:0]  cur_minute = 6'd0, cur_second = 6'd0;
  logic        set_active, load;
  logic [2:0]  field_sel;
  logic [15:0] edit_year;
  logic [3:0]  edit_month;
  logic [4:0]  edit_day, edit_hour;
  logic [5:0]  edit_minute, edit_second;

  int n_tests = 0;
  int n_fail  = 0;

  time_set_ctrl #(.REPEAT_DLY(10), .REPEAT_PER(4), .YEAR_MIN(2000), .YEAR_MAX(2099)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]), .btn_right(btns[3]), .btn_mid(btns[4]),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_active(set_active), .field_sel(field_sel),
    .edit_year(edit_year), .edit_month(edit_month), .edit_day(edit_day),
    .edit_hour(edit_hour), .edit_minute(edit_minute), .edit_second(edit_second),
    .load(load)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press followed by one release cycle.
  task automatic pulse(input logic [4:0] mask);
    btns = mask;
    tick();
    btns = '0;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " set_active"}, 32'(set_active), 0);
    check({tag, " load"},       32'(load), 0);
    check({tag, " field"},      32'(field_sel), 0);
    check({tag, " year"},       32'(edit_year), 2000);
    check({tag, " month"},      32'(edit_month), 1);
    check({tag, " day"},        32'(edit_day), 1);
    check({tag, " hour"},       32'(edit_hour), 0);
    check({tag, " minute"},     32'(edit_minute), 0);
    check({tag, " second"},     32'(edit_second), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_min;
    logic load_seen;

    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Enter edit with a leap-day snapshot
    cur_year = 16'd2024; cur_month = 4'd2; cur_day = 5'd29;
    cur_hour = 5'd13; cur_minute = 6'd45; cur_second = 6'd59;
    btns = B_MID;
    tick();
    check("enter set_active", 32'(set_active), 1);
    check("enter year",   32'(edit_year), 2024);
    check("enter month",  32'(edit_month), 2);
    check("enter day",    32'(edit_day), 29);
    check("enter hour",   32'(edit_hour), 13);
    check("enter minute", 32'(edit_minute), 45);
    check("enter second", 32'(edit_second), 59);
    check("enter field",  32'(field_sel), 0);
    btns = '0;
    tick();

    // Seconds wrap without carry
    pulse(B_UP);
    check("sec wrap up", 32'(edit_second), 0);
    check("sec no carry", 32'(edit_minute), 45);
    pulse(B_DOWN);
    check("sec wrap down", 32'(edit_second), 59);

    // Field select wrap right
    pulse(B_RIGHT);
    check("right wrap", 32'(field_sel), 5);

    // Year step with Feb 29 clamp
    pulse(B_UP);
    check("year up", 32'(edit_year), 2025);
    check("year clamp day", 32'(edit_day), 28);
    pulse(B_DOWN);
    check("year down", 32'(edit_year), 2024);
    check("year down day", 32'(edit_day), 28);
    for (int i = 0; i < 24; i++) pulse(B_DOWN);
    check("year min", 32'(edit_year), 2000);
    pulse(B_DOWN);
    check("year wrap down", 32'(edit_year), 2099);
    pulse(B_UP);
    check("year wrap up", 32'(edit_year), 2000);

    // Left wrap and walk to day field
    pulse(B_LEFT);
    check("left wrap", 32'(field_sel), 0);
    repeat (3) pulse(B_LEFT);
    check("field day", 32'(field_sel), 3);

    // Day stepping in Feb 2000 (leap by the 400 rule)
    pulse(B_UP);
    check("day to 29", 32'(edit_day), 29);
    pulse(B_UP);
    check("day wrap up", 32'(edit_day), 1);
    pulse(B_DOWN);
    check("day wrap down", 32'(edit_day), 29);

    // Month step, then clamp 31 -> 29 going Jan -> Feb
    pulse(B_LEFT);
    pulse(B_DOWN);
    check("month down", 32'(edit_month), 1);
    check("month down day", 32'(edit_day), 29);
    pulse(B_RIGHT);
    pulse(B_UP);
    pulse(B_UP);
    check("day 31 jan", 32'(edit_day), 31);
    pulse(B_LEFT);
    pulse(B_UP);
    check("month up", 32'(edit_month), 2);
    check("month clamp day", 32'(edit_day), 29);

    // Conflicting buttons are ignored
    pulse(B_UP | B_DOWN);
    check("up+down month", 32'(edit_month), 2);
    pulse(B_LEFT | B_RIGHT);
    check("left+right field", 32'(field_sel), 4);

    // Month wrap both ways
    pulse(B_DOWN);
    pulse(B_DOWN);
    check("month wrap down", 32'(edit_month), 12);
    pulse(B_UP);
    check("month wrap up", 32'(edit_month), 1);

    // Minute field, brought to 0
    repeat (3) pulse(B_RIGHT);
    check("field minute", 32'(field_sel), 1);
    repeat (15) pulse(B_UP);
    check("minute to 0", 32'(edit_minute), 0);
    check("hour untouched", 32'(edit_hour), 13);

    // Auto-repeat: steps visible at +1, +10, +14, +18
    btns = B_UP;
    for (int k = 1; k <= 19; k++) begin
      tick();
      exp_min = 1 + ((k >= 10) ? 1 + (k - 10) / 4 : 0);
      check($sformatf("repeat +%0d", k), 32'(edit_minute), 32'(exp_min));
    end
    btns = '0;
    tick();
    check("repeat release", 32'(edit_minute), 4);

    // Commit
    btns = B_MID;
    tick();
    check("commit load", 32'(load), 1);
    check("commit set_active", 32'(set_active), 0);
    btns = '0;
    tick();
    check("after load", 32'(load), 0);
    check("after set_active", 32'(set_active), 0);
    check("hold minute", 32'(edit_minute), 4);
    check("hold month", 32'(edit_month), 1);

    // Idle ignores non-middle buttons
    pulse(B_UP);
    pulse(B_LEFT);
    check("idle minute", 32'(edit_minute), 4);
    check("idle field", 32'(field_sel), 1);
    check("idle set_active", 32'(set_active), 0);

    // Re-enter and abort with reset
    cur_year = 16'd2031; cur_month = 4'd7; cur_day = 5'd4;
    cur_hour = 5'd8; cur_minute = 6'd9; cur_second = 6'd10;
    pulse(B_MID);
    check("reenter set_active", 32'(set_active), 1);
    check("reenter year", 32'(edit_year), 2031);
    btns = B_MID;
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    load_seen = 1'b0;
    repeat (3) begin
      tick();
      load_seen = load_seen | load;
    end
    btns = '0;
    tick();
    rst_n = 1'b1;
    tick();
    load_seen = load_seen | load;
    check("abort no load", 32'(load_seen), 0);
    check("abort idle", 32'(set_active), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
